// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding, SPI mode
// encodings and a width helper for the divider and edge counters.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // Modes encoded as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCK half-period divider: counts 0..HALF_DIV-1 while run is high and fires
// tick on the last count; the count is held at zero whenever run is low.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int HALF_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int W = cnt_width(HALF_DIV);

  logic [W-1:0] count;

  assign tick = run && (count == W'(HALF_DIV - 1));

  // Wrapping on tick doubles as the clear on every state change.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master (frame length, SCK divider, CPOL/CPHA) with CS setup/hold.
// Defining SPI_MASTER_LSB_FIRST_EN adds the lsb_first input for LSB-first frames.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = 40,
  parameter int HALF_DIV   = 32,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output spi_state_t            debug_state
);

  // Handshake: start is a request taken only while busy is low (IDLE); a start
  // seen while busy is dropped, and done pulses once when rx_data is updated.

  localparam int EW = cnt_width(2 * FRAME_BITS + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * FRAME_BITS);

  spi_state_t state, state_next;
  logic tick, lsb_in, lsb_q;
  logic edge_now, leading, sample_edge, shift_edge;
  logic [EW-1:0] edge_cnt, edge_num;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr, rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(input logic [FRAME_BITS-1:0] v, input logic lsb);
    return lsb ? v[0] : v[FRAME_BITS-1];
  endfunction

  function automatic logic [FRAME_BITS-1:0] advance(input logic [FRAME_BITS-1:0] v,
                                                    input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  spi_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (state != IDLE),
    .tick  (tick)
  );

  // edge_num is the SCK edge about to be produced (1-based); odd edges lead.
  assign edge_num    = edge_cnt + 1'b1;
  assign edge_now    = (state == XFER) && tick;
  assign leading     = edge_num[0];
  assign sample_edge = edge_now && (leading != CPHA);
  assign shift_edge  = edge_now && (leading == CPHA) && (edge_num != LAST_EDGE);
  assign rx_next     = lsb_q ? ((rx_sr >> 1) | (FRAME_BITS'(miso) << (FRAME_BITS - 1)))
                             : ((rx_sr << 1) | FRAME_BITS'(miso));
  assign busy        = (state != IDLE);
  assign debug_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (tick) state_next = XFER;
      XFER:    if (tick && (edge_num == LAST_EDGE)) state_next = HOLD;
      HOLD:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs       <= 1'b1;
      sck      <= CPOL;
      mosi     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      lsb_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cs       <= 1'b0;
            edge_cnt <= '0;
            lsb_q    <= lsb_in;
            // CPHA=0 presents the first bit during setup, so it is consumed here.
            if (CPHA) begin
              tx_sr <= tx_data;
            end else begin
              mosi  <= first_bit(tx_data, lsb_in);
              tx_sr <= advance(tx_data, lsb_in);
            end
          end
        end
        XFER: begin
          if (tick) begin
            edge_cnt <= edge_num;
            sck      <= (edge_num == LAST_EDGE) ? CPOL : ~sck;
            if (sample_edge) rx_sr <= rx_next;
            if (shift_edge) begin
              mosi  <= first_bit(tx_sr, lsb_q);
              tx_sr <= advance(tx_sr, lsb_q);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            rx_data <= rx_sr;
            done    <= 1'b1;
            cs      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: four 8-bit mode instances with an SPI slave
// model, a default-parameter loopback instance and a 1-bit / HALF_DIV=1 instance.
module tb_spi_master;
  import spi_pkg::*;

  localparam int MF = 8;
  localparam int MH = 2;
  localparam int M_DONE = 1 + MH * (2 * MF + 2);
  localparam int DF = 40;
  localparam int DH = 32;
  localparam int D_DONE = 1 + DH * (2 * DF + 2);
  localparam int TF = 1;
  localparam int TH = 1;
  localparam int T_DONE = 1 + TH * (2 * TF + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- mode instances (index = {CPOL,CPHA}) ----------------
  logic [3:0] start_m = '0;
  logic [3:0] busy_m, done_m, cs_m, sck_m, mosi_m;
  logic [3:0] miso_m = '0;
  logic [MF-1:0] tx_m [4];
  logic [MF-1:0] rx_m [4];
  spi_state_t st_m [4];
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic [3:0] lsb_m = '0;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_master #(.FRAME_BITS(MF), .HALF_DIV(MH), .CPOL(1'((g / 2) % 2)), .CPHA(1'(g % 2))) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_m[g]),
      .tx_data     (tx_m[g]),
`ifdef SPI_MASTER_LSB_FIRST_EN
      .lsb_first   (lsb_m[g]),
`endif
      .busy        (busy_m[g]),
      .done        (done_m[g]),
      .rx_data     (rx_m[g]),
      .cs          (cs_m[g]),
      .sck         (sck_m[g]),
      .mosi        (mosi_m[g]),
      .miso        (miso_m[g]),
      .debug_state (st_m[g])
    );
  end

  // ---------------- default instance, mosi looped to miso ----------------
  logic start_d = 1'b0;
  logic [DF-1:0] tx_d = '0;
  logic [DF-1:0] rx_d;
  logic busy_d, done_d, cs_d, sck_d, mosi_d;
  spi_state_t st_d;

  spi_master u_def (
    .clk         (clk),
    .reset       (reset),
    .start       (start_d),
    .tx_data     (tx_d),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first   (1'b0),
`endif
    .busy        (busy_d),
    .done        (done_d),
    .rx_data     (rx_d),
    .cs          (cs_d),
    .sck         (sck_d),
    .mosi        (mosi_d),
    .miso        (mosi_d),
    .debug_state (st_d)
  );

  // ---------------- tiny instance: 1 bit, HALF_DIV=1, mode 3, loopback ----------------
  logic start_t = 1'b0;
  logic [TF-1:0] tx_t = '0;
  logic [TF-1:0] rx_t;
  logic busy_t, done_t, cs_t, sck_t, mosi_t;
  spi_state_t st_t;

  spi_master #(.FRAME_BITS(TF), .HALF_DIV(TH), .CPOL(1'b1), .CPHA(1'b1)) u_tiny (
    .clk         (clk),
    .reset       (reset),
    .start       (start_t),
    .tx_data     (tx_t),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first   (1'b0),
`endif
    .busy        (busy_t),
    .done        (done_t),
    .rx_data     (rx_t),
    .cs          (cs_t),
    .sck         (sck_t),
    .mosi        (mosi_t),
    .miso        (mosi_t),
    .debug_state (st_t)
  );

  // ---------------- SPI slave model for the mode instances ----------------
  // Shifts sl_word out MSB first on the line and records what it sees on mosi.
  logic [MF-1:0] sl_word [4];
  logic [MF-1:0] sl_shift [4];
  logic [MF-1:0] sl_in [4];
  int sl_n [4];
  logic [3:0] prev_cs = 4'b1111;
  logic [3:0] prev_sck = 4'b1100;

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      logic pol, pha, lead;
      pol = (m >= 2);
      pha = (m % 2 == 1);
      if (prev_cs[m] && !cs_m[m]) begin
        sl_in[m] = '0;
        sl_n[m] = 0;
        sl_shift[m] = sl_word[m];
        if (!pha) begin
          miso_m[m] = sl_shift[m][MF-1];
          sl_shift[m] = sl_shift[m] << 1;
        end
      end else if (!cs_m[m] && (sck_m[m] !== prev_sck[m])) begin
        lead = (sck_m[m] != pol);
        if (lead != pha) begin
          sl_in[m] = {sl_in[m][MF-2:0], mosi_m[m]};
          sl_n[m] = sl_n[m] + 1;
        end else begin
          miso_m[m] = sl_shift[m][MF-1];
          sl_shift[m] = sl_shift[m] << 1;
        end
      end
      prev_cs[m] = cs_m[m];
      prev_sck[m] = sck_m[m];
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // One frame on mode instance m. With pre=1 the start was already driven by
  // the previous call. chain=1 re-requests on the done cycle with nxt_tx/nxt_sw.
  task automatic xfer_m(input int m, input logic [7:0] tx, input logic [7:0] sw,
                        input logic [7:0] exp_rx, input logic [7:0] exp_mosi,
                        input int p1, input int p2, input bit chain, input bit pre,
                        input logic [7:0] nxt_tx, input logic [7:0] nxt_sw);
    int cyc, done_cyc, first_low, last_low, nlow;
    logic busy1, pol;
    pol = (m >= 2);
    if (!pre) begin
      tx_m[m] = tx;
      sl_word[m] = sw;
      start_m[m] = 1'b1;
      @(negedge clk);
    end
    start_m[m] = 1'b0;
    busy1 = busy_m[m];
    cyc = 1;
    done_cyc = -1;
    first_low = -1;
    last_low = -1;
    nlow = 0;
    while (cyc < 200 && done_cyc < 0) begin
      if (!cs_m[m]) begin
        nlow++;
        if (first_low < 0) first_low = cyc;
        last_low = cyc;
      end
      if (done_m[m]) begin
        done_cyc = cyc;
      end else begin
        if (cyc == p1 || cyc == p2) begin
          start_m[m] = 1'b1;
          tx_m[m] = ~tx;
        end else begin
          start_m[m] = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (done_cyc !== M_DONE) begin
      failures++;
      $display("FAIL done_cycle m=%0d: got %0d expected %0d", m, done_cyc, M_DONE);
    end
    checks++;
    if (first_low !== 1 || last_low !== M_DONE - 1 || nlow !== M_DONE - 1) begin
      failures++;
      $display("FAIL cs_window m=%0d: got first=%0d last=%0d count=%0d expected 1..%0d", m,
               first_low, last_low, nlow, M_DONE - 1);
    end
    checks++;
    if (busy1 !== 1'b1 || busy_m[m] !== 1'b0) begin
      failures++;
      $display("FAIL busy m=%0d: got start=%b end=%b expected 1 and 0", m, busy1, busy_m[m]);
    end
    checks++;
    if (cs_m[m] !== 1'b1) begin
      failures++;
      $display("FAIL cs_at_done m=%0d: got %b expected 1", m, cs_m[m]);
    end
    checks++;
    if (rx_m[m] !== exp_rx) begin
      failures++;
      $display("FAIL rx_data m=%0d: got %h expected %h", m, rx_m[m], exp_rx);
    end
    checks++;
    if (sl_in[m] !== exp_mosi || sl_n[m] !== MF) begin
      failures++;
      $display("FAIL mosi_seq m=%0d: got %h (%0d bits) expected %h (%0d bits)", m, sl_in[m],
               sl_n[m], exp_mosi, MF);
    end
    checks++;
    if (sck_m[m] !== pol) begin
      failures++;
      $display("FAIL sck_idle m=%0d: got %b expected %b", m, sck_m[m], pol);
    end
    if (chain) begin
      tx_m[m] = nxt_tx;
      sl_word[m] = nxt_sw;
      start_m[m] = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (done_m[m] !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse m=%0d: got %b expected 0", m, done_m[m]);
    end
    if (chain) begin
      checks++;
      if (cs_m[m] !== 1'b0) begin
        failures++;
        $display("FAIL cs_gap m=%0d: got %b expected 0", m, cs_m[m]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (cs_m[m] !== 1'b1 || busy_m[m] !== 1'b0 || done_m[m] !== 1'b0 || mosi_m[m] !== 1'b0 ||
          sck_m[m] !== (m >= 2) || rx_m[m] !== '0 || st_m[m] !== IDLE) begin
        failures++;
        $display("FAIL reset_state m=%0d: got cs=%b busy=%b done=%b mosi=%b sck=%b rx=%h", m,
                 cs_m[m], busy_m[m], done_m[m], mosi_m[m], sck_m[m], rx_m[m]);
      end
    end
    checks++;
    if (cs_d !== 1'b1 || sck_d !== 1'b0 || rx_d !== '0 || cs_t !== 1'b1 || sck_t !== 1'b1) begin
      failures++;
      $display("FAIL reset_other: got cs_d=%b sck_d=%b rx_d=%h cs_t=%b sck_t=%b", cs_d, sck_d,
               rx_d, cs_t, sck_t);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [7:0] a, b;
    for (int m = 0; m < 4; m++) begin
      xfer_m(m, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int k = 0; k < 2; k++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        xfer_m(m, a, b, b, a, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, s1, s2;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    s1 = 8'($urandom_range(0, 255));
    s2 = 8'($urandom_range(0, 255));
    xfer_m(0, a, s1, s1, a, 5, 20, 1'b1, 1'b0, b, s2);
    xfer_m(0, b, s2, s2, b, 0, 0, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    int ndone;
    tx_m[0] = 8'hFF;
    sl_word[0] = 8'($urandom_range(0, 255));
    start_m[0] = 1'b1;
    @(negedge clk);
    start_m[0] = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (cs_m[0] !== 1'b0 || mosi_m[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_transfer: got cs=%b mosi=%b expected 0 and 1", cs_m[0], mosi_m[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cs_m[0] !== 1'b1 || sck_m[0] !== 1'b0 || mosi_m[0] !== 1'b0 || busy_m[0] !== 1'b0 ||
        rx_m[0] !== '0 || done_m[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: got cs=%b sck=%b mosi=%b busy=%b rx=%h done=%b", cs_m[0],
               sck_m[0], mosi_m[0], busy_m[0], rx_m[0], done_m[0]);
    end
    reset = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_m[0] || !cs_m[0]) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL no_done_after_abort: got %0d active cycles expected 0", ndone);
    end
    xfer_m(0, 8'h5A, 8'hC3, 8'hC3, 8'h5A, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_defaults(input logic [DF-1:0] tx);
    int cyc, done_cyc, r1, r2;
    logic prev;
    tx_d = tx;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    cyc = 1;
    done_cyc = -1;
    r1 = -1;
    r2 = -1;
    prev = sck_d;
    while (cyc < D_DONE + 100 && done_cyc < 0) begin
      if (sck_d && !prev) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      prev = sck_d;
      if (done_d) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (done_cyc !== D_DONE) begin
      failures++;
      $display("FAIL def_done_cycle: got %0d expected %0d", done_cyc, D_DONE);
    end
    checks++;
    if (rx_d !== tx) begin
      failures++;
      $display("FAIL def_rx_data: got %h expected %h", rx_d, tx);
    end
    checks++;
    if (r2 - r1 !== 2 * DH) begin
      failures++;
      $display("FAIL def_sck_period: got %0d expected %0d", r2 - r1, 2 * DH);
    end
    checks++;
    if (cs_d !== 1'b1 || sck_d !== 1'b0) begin
      failures++;
      $display("FAIL def_idle: got cs=%b sck=%b expected 1 and 0", cs_d, sck_d);
    end
    @(negedge clk);
  endtask

  task automatic test_tiny();
    int cyc, done_cyc;
    logic [TF-1:0] b;
    for (int k = 0; k < 4; k++) begin
      b = TF'(k % 2 == 0 ? 1 : $urandom_range(0, 1));
      tx_t = b;
      start_t = 1'b1;
      @(negedge clk);
      start_t = 1'b0;
      cyc = 1;
      done_cyc = -1;
      while (cyc < 50 && done_cyc < 0) begin
        if (done_t) done_cyc = cyc;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
      checks++;
      if (done_cyc !== T_DONE || rx_t !== b) begin
        failures++;
        $display("FAIL tiny_frame: got done=%0d rx=%b expected done=%0d rx=%b", done_cyc, rx_t,
                 T_DONE, b);
      end
      checks++;
      if (sck_t !== 1'b1 || cs_t !== 1'b1) begin
        failures++;
        $display("FAIL tiny_idle: got sck=%b cs=%b expected 1 and 1", sck_t, cs_t);
      end
      @(negedge clk);
    end
  endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
  task automatic test_lsb_first();
    logic [7:0] a, s;
    lsb_m[0] = 1'b1;
    xfer_m(0, 8'h01, 8'h01, 8'h80, 8'h80, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    a = 8'($urandom_range(0, 255));
    s = 8'($urandom_range(0, 255));
    xfer_m(0, a, s, rev8(s), rev8(a), 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    lsb_m[0] = 1'b0;
    a = 8'($urandom_range(0, 255));
    xfer_m(0, a, s, s, a, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask
`endif

  initial begin
    logic [63:0] r;
    for (int m = 0; m < 4; m++) begin
      tx_m[m] = '0;
      sl_word[m] = '0;
    end
    test_reset();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    test_defaults(40'h12_3456_789A);
    r = {$urandom(), $urandom()};
    test_defaults(r[DF-1:0]);
    test_tiny();
`ifdef SPI_MASTER_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
